mux8_rr_sched: RTL

Round-robin scheduler that shares the team's 8:1 single-bit multiplexer among eight requesters. It arbitrates on a per-cycle request vector, drives the mux select (`Sel`) and a one-hot grant back to the winner, and enforces a bounded grant length so that no requester can starve the others. It sits directly in front of the mux's `Sel` input; the mux data inputs `I[7:0]` connect to the requesters unchanged.

---
 rtl/mux8_rr_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler driving the select of a shared 8:1 mux.
// One grant at a time. A grant ends when the owner drops its request, or when
// it has held the mux for BURST cycles while another requester is waiting.
// Every grant is followed by one idle cycle before the next grant.
module mux8_rr_sched #(
  parameter int unsigned BURST = 4  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] Sel,
  output logic       Sel_valid,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;

  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  first_off;
  logic [2:0]  pick_idx;
  logic        contended;
  logic        owner_req;

  // Rotate the request vector so bit 0 is the search start, then take the
  // lowest set bit; adding ptr back wraps modulo 8 through the 3-bit sum.
  always_comb begin
    req_dbl   = {req, req};
    req_rot   = req_dbl[ptr_q +: 8];
    first_off = 3'd0;
    for (int off = 7; off >= 0; off--) begin
      if (req_rot[off]) begin
        first_off = 3'(off);
      end
    end
    pick_idx = ptr_q + first_off;
  end

  // Grant-ending conditions: the owner's own request and any other waiter.
  always_comb begin
    owner_req = req[owner_q];
    contended = |(req & ~gnt_q);
  end

  // Next-state logic for the IDLE/GRANT machine and its datapath registers.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (req != 8'd0) begin
          owner_d = pick_idx;
          sel_d   = pick_idx;
          gnt_d   = 8'd1 << pick_idx;
          cnt_d   = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || ((cnt_q == CNT_MAX) && contended)) begin
          // Release or preemption both hand the search start to the
          // requester just after the outgoing owner.
          state_d = IDLE;
          gnt_d   = 8'd0;
          ptr_d   = owner_q + 3'd1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'd0;
      end
    endcase
  end

  // State and datapath registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 8'd0;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt       = gnt_q;
  assign Sel       = sel_q;
  assign Sel_valid = (state_q == GRANT);
  assign busy      = (state_q == GRANT);

endmodule
